// File: rtl/axis_upsizer.sv
// AXI-Stream width upsizer: packs RATIO narrow beats into one wide word, first beat in the LSBs.
// A tlast flushes a partial word early; unfilled lanes read zero and m_tfill counts the valid lanes.
module axis_upsizer #(
    parameter int IN_WIDTH  = 16,
    parameter int RATIO     = 2,
    parameter int OUT_WIDTH = IN_WIDTH * RATIO,
    parameter int CNT_BITS  = (RATIO > 1) ? $clog2(RATIO) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [IN_WIDTH-1:0]  s_tdata,
    input  logic                 s_tvalid,
    input  logic                 s_tlast,
    output logic                 s_tready,
    output logic [OUT_WIDTH-1:0] m_tdata,
    output logic                 m_tvalid,
    output logic                 m_tlast,
    output logic [CNT_BITS:0]    m_tfill,
    input  logic                 m_tready
);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t              state_reg, state_next;
    logic [CNT_BITS-1:0] idx_reg, idx_next;
    logic                last_reg, last_next;
    logic [CNT_BITS:0]   fill_reg, fill_next;
    logic                accept;
    logic                close;

    // A held word may leave in the same cycle a new lane 0 arrives, so ready passes m_tready through.
    assign s_tready = (state_reg == FILL) || m_tready;
    assign accept   = s_tvalid && s_tready;
    assign close    = (idx_reg == CNT_BITS'(RATIO - 1)) || s_tlast;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= FILL;
            idx_reg   <= '0;
            last_reg  <= 1'b0;
            fill_reg  <= '0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            last_reg  <= last_next;
            fill_reg  <= fill_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        last_next  = last_reg;
        fill_next  = fill_reg;
        if (accept) begin
            if (close) begin
                state_next = HOLD;
                last_next  = s_tlast;
                fill_next  = (CNT_BITS + 1)'(idx_reg) + (CNT_BITS + 1)'(1);
                idx_next   = '0;
            end else begin
                state_next = FILL;
                last_next  = 1'b0;
                fill_next  = '0;
                idx_next   = idx_reg + CNT_BITS'(1);
            end
        end else if ((state_reg == HOLD) && m_tready) begin
            state_next = FILL;
            last_next  = 1'b0;
            fill_next  = '0;
        end
    end

    // Writing lane 0 wipes the upper lanes so a flushed partial word is zero-padded.
    for (genvar gi = 0; gi < RATIO; gi++) begin : g_lane
        logic [IN_WIDTH-1:0] lane_reg;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                lane_reg <= '0;
            end else if (accept) begin
                if (idx_reg == CNT_BITS'(gi)) begin
                    lane_reg <= s_tdata;
                end else if (idx_reg == '0) begin
                    lane_reg <= '0;
                end
            end
        end

        assign m_tdata[gi*IN_WIDTH +: IN_WIDTH] = lane_reg;
    end

    assign m_tvalid = (state_reg == HOLD);
    assign m_tlast  = last_reg;
    assign m_tfill  = fill_reg;

endmodule

// File: tb/tb_axis_upsizer.sv
// Bench for axis_upsizer: RATIO=2 and RATIO=4 instances share one input stream and are checked
// against a queue-style packing model plus directed expectations.
module tb_axis_upsizer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] s_tdata;
    logic        s_tvalid;
    logic        s_tlast;
    logic        m_tready;

    logic        r2_s_tready, r2_m_tvalid, r2_m_tlast;
    logic [31:0] r2_m_tdata;
    logic [1:0]  r2_m_tfill;
    logic        r4_s_tready, r4_m_tvalid, r4_m_tlast;
    logic [63:0] r4_m_tdata;
    logic [2:0]  r4_m_tfill;

    int vectors     = 0;
    int miscompares = 0;
    int pops2       = 0;
    int pops4       = 0;

    // model state, index 0 = RATIO 2, index 1 = RATIO 4
    bit          held  [2];
    logic [63:0] hword [2];
    int          hfill [2];
    bit          hlast [2];
    logic [15:0] cur   [2][4];
    int          cur_n [2];

    always #5 clk = ~clk;

    axis_upsizer #(.IN_WIDTH(16), .RATIO(2)) u_r2 (
        .clk(clk), .rst_n(rst_n),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(r2_s_tready),
        .m_tdata(r2_m_tdata), .m_tvalid(r2_m_tvalid), .m_tlast(r2_m_tlast), .m_tfill(r2_m_tfill),
        .m_tready(m_tready)
    );

    axis_upsizer #(.IN_WIDTH(16), .RATIO(4)) u_r4 (
        .clk(clk), .rst_n(rst_n),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(r4_s_tready),
        .m_tdata(r4_m_tdata), .m_tvalid(r4_m_tvalid), .m_tlast(r4_m_tlast), .m_tfill(r4_m_tfill),
        .m_tready(m_tready)
    );

    function automatic int ratio_of(input int i);
        return (i == 0) ? 2 : 4;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void mdl_reset();
        for (int i = 0; i < 2; i++) begin
            held[i]  = 1'b0;
            hword[i] = '0;
            hfill[i] = 0;
            hlast[i] = 1'b0;
            cur_n[i] = 0;
        end
    endfunction

    // One clock edge of the packing rules: pop first, then collect the accepted beat.
    function automatic void mdl_step(input int i, input bit v, input logic [15:0] d,
                                     input bit l, input bit r);
        bit rdy;
        rdy = !held[i] || r;
        if (held[i] && r) held[i] = 1'b0;
        if (v && rdy) begin
            cur[i][cur_n[i]] = d;
            cur_n[i]++;
            if (cur_n[i] == ratio_of(i) || l) begin
                hword[i] = '0;
                for (int k = 0; k < cur_n[i]; k++) hword[i][k*16 +: 16] = cur[i][k];
                hfill[i] = cur_n[i];
                hlast[i] = l;
                held[i]  = 1'b1;
                cur_n[i] = 0;
            end
        end
    endfunction

    task automatic check_outs();
        chk("r2_m_tvalid", 64'(r2_m_tvalid), 64'(held[0]));
        chk("r2_m_tlast",  64'(r2_m_tlast),  64'(held[0] && hlast[0]));
        chk("r2_m_tfill",  64'(r2_m_tfill),  held[0] ? 64'(hfill[0]) : 64'd0);
        if (held[0]) chk("r2_m_tdata", 64'(r2_m_tdata), hword[0]);
        chk("r4_m_tvalid", 64'(r4_m_tvalid), 64'(held[1]));
        chk("r4_m_tlast",  64'(r4_m_tlast),  64'(held[1] && hlast[1]));
        chk("r4_m_tfill",  64'(r4_m_tfill),  held[1] ? 64'(hfill[1]) : 64'd0);
        if (held[1]) chk("r4_m_tdata", r4_m_tdata, hword[1]);
    endtask

    // Called at a falling edge: drive, check ready, take the rising edge, check outputs.
    task automatic tick(input bit v, input logic [15:0] d, input bit l, input bit r);
        s_tvalid = v;
        s_tdata  = d;
        s_tlast  = l;
        m_tready = r;
        #1;
        chk("r2_s_tready", 64'(r2_s_tready), 64'(!held[0] || r));
        chk("r4_s_tready", 64'(r4_s_tready), 64'(!held[1] || r));
        if (r2_m_tvalid && r) pops2++;
        if (r4_m_tvalid && r) pops4++;
        @(posedge clk);
        mdl_step(0, v, d, l, r);
        mdl_step(1, v, d, l, r);
        @(negedge clk);
        check_outs();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_r2_m_tvalid"}, 64'(r2_m_tvalid), 64'd0);
        chk({tag, "_r2_m_tlast"},  64'(r2_m_tlast),  64'd0);
        chk({tag, "_r2_m_tfill"},  64'(r2_m_tfill),  64'd0);
        chk({tag, "_r2_m_tdata"},  64'(r2_m_tdata),  64'd0);
        chk({tag, "_r4_m_tvalid"}, 64'(r4_m_tvalid), 64'd0);
        chk({tag, "_r4_m_tfill"},  64'(r4_m_tfill),  64'd0);
        chk({tag, "_r4_m_tdata"},  r4_m_tdata,       64'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        s_tdata  = '0;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        m_tready = 1'b0;
        mdl_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;

        // two full words on each instance
        tick(1, 16'h1111, 0, 1);
        tick(1, 16'h2222, 0, 1);
        chk("t1_r2_word0", 64'(r2_m_tdata), 64'h0000_0000_2222_1111);
        chk("t1_r2_fill0", 64'(r2_m_tfill), 64'd2);
        chk("t1_r2_last0", 64'(r2_m_tlast), 64'd0);
        tick(1, 16'h3333, 0, 1);
        tick(1, 16'h4444, 0, 1);
        chk("t1_r2_word1", 64'(r2_m_tdata), 64'h0000_0000_4444_3333);
        chk("t1_r4_word",  r4_m_tdata,      64'h4444_3333_2222_1111);
        chk("t1_r4_fill",  64'(r4_m_tfill), 64'd4);

        // tlast flushes a 3-lane word on RATIO 4, and a lane-0-only word on RATIO 2
        tick(1, 16'hAAAA, 0, 1);
        tick(1, 16'hBBBB, 0, 1);
        chk("t2_r4_early_valid", 64'(r4_m_tvalid), 64'd0);
        tick(1, 16'hCCCC, 1, 1);
        chk("t2_r4_valid", 64'(r4_m_tvalid), 64'd1);
        chk("t2_r4_word",  r4_m_tdata,       64'h0000_CCCC_BBBB_AAAA);
        chk("t2_r4_fill",  64'(r4_m_tfill),  64'd3);
        chk("t2_r4_last",  64'(r4_m_tlast),  64'd1);
        chk("t2_r2_word",  64'(r2_m_tdata),  64'h0000_0000_0000_CCCC);
        chk("t2_r2_fill",  64'(r2_m_tfill),  64'd1);
        chk("t2_r2_last",  64'(r2_m_tlast),  64'd1);
        tick(0, 16'h0000, 0, 1);

        // sustained throughput: 100 beats, then one drain cycle
        pops2 = 0;
        pops4 = 0;
        for (int n = 0; n < 100; n++) tick(1, 16'($urandom), 0, 1);
        tick(0, 16'h0000, 0, 1);
        chk("t4_r2_words", 64'(pops2), 64'd50);
        chk("t4_r4_words", 64'(pops4), 64'd25);

        // stall a held word for 5 cycles, then pop and accept lane 0 together
        tick(1, 16'h0101, 0, 0);
        tick(1, 16'h0202, 0, 0);
        for (int n = 0; n < 5; n++) begin
            tick(1, 16'($urandom), 0, 0);
            chk("t3_r2_stall_ready", 64'(r2_s_tready), 64'd0);
            chk("t3_r2_stable", 64'(r2_m_tdata), 64'h0000_0000_0202_0101);
        end
        tick(1, 16'h0303, 0, 1);
        chk("t3_r2_after_release", 64'(r2_m_tvalid), 64'd0);
        tick(0, 16'h0000, 0, 1);

        // reset with one lane pending in the RATIO 2 instance
        rst_n = 1'b0;
        #1;
        chk_zero("t5_in_reset");
        chk("t5_r2_s_tready", 64'(r2_s_tready), 64'd1);
        mdl_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick(1, 16'h5A5A, 0, 1);
        tick(1, 16'hA5A5, 0, 1);
        chk("t5_r2_word",  64'(r2_m_tdata),  64'h0000_0000_A5A5_5A5A);
        chk("t5_r2_valid", 64'(r2_m_tvalid), 64'd1);

        // random traffic with backpressure and early tlast
        for (int n = 0; n < 3000; n++) begin
            tick($urandom_range(0, 9) < 7, 16'($urandom), $urandom_range(0, 9) == 0,
                 $urandom_range(0, 3) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
